// File: rtl/baseerat_mux_sched_if.sv
// baseerat_mux_sched bus bundle.
// Two input streams, one registered output stream, status.
interface baseerat_mux_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] din0;
    logic                  din0_valid;
    logic                  din0_last;
    logic                  din0_ready;
    logic [DATA_WIDTH-1:0] din1;
    logic                  din1_valid;
    logic                  din1_last;
    logic                  din1_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_last;
    logic                  dout_ready;
    logic                  sel;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  pkt_cnt0;
    logic [CNT_WIDTH-1:0]  pkt_cnt1;

    modport master (
        output din0, din0_valid, din0_last,
        input  din0_ready,
        output din1, din1_valid, din1_last,
        input  din1_ready,
        input  dout, dout_valid, dout_last,
        output dout_ready,
        input  sel, busy, pkt_cnt0, pkt_cnt1
    );

    modport slave (
        input  din0, din0_valid, din0_last,
        output din0_ready,
        input  din1, din1_valid, din1_last,
        output din1_ready,
        output dout, dout_valid, dout_last,
        input  dout_ready,
        output sel, busy, pkt_cnt0, pkt_cnt1
    );
endinterface

// File: rtl/baseerat_mux_sched.sv
// baseerat_mux_sched: packet-granular 2:1 round-robin scheduler
// with a one-entry registered output stage and packet counters.
module baseerat_mux_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic                clk,
    input logic                resetn,
    baseerat_mux_sched_if.slave bus
);
    localparam int NSEC = DATA_WIDTH / 16;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  sel_q, sel_d;
    logic                  dv_q, dl_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt1_q;
    logic [DATA_WIDTH-1:0] mux_d;
    logic                  mux_last;
    logic                  out_free;
    logic                  gnt0, gnt1;
    logic                  acc0, acc1, fin0, fin1;

    assign gnt0     = (state_q == GNT0);
    assign gnt1     = (state_q == GNT1);
    assign out_free = !dv_q || bus.dout_ready;
    assign acc0     = gnt0 && out_free && bus.din0_valid;
    assign acc1     = gnt1 && out_free && bus.din1_valid;
    assign fin0     = acc0 && bus.din0_last;
    assign fin1     = acc1 && bus.din1_last;

    // Section-wise 2:1 data mux steered by the current grant
    for (genvar s = 0; s < NSEC; s++) begin : g_sec
        assign mux_d[s*16 +: 16] = gnt0 ? bus.din0[s*16 +: 16]
                                        : bus.din1[s*16 +: 16];
    end
    assign mux_last = gnt0 ? bus.din0_last : bus.din1_last;

    // Grant decision: round-robin in IDLE, switch only at packet end
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        sel_d      = sel_q;
        unique case (state_q)
            IDLE: begin
                if (bus.din0_valid && bus.din1_valid)
                    state_d = last_gnt_q ? GNT0 : GNT1;
                else if (bus.din0_valid)
                    state_d = GNT0;
                else if (bus.din1_valid)
                    state_d = GNT1;
            end
            GNT0: begin
                if (fin0) begin
                    last_gnt_d = 1'b0;
                    if (bus.din1_valid)      state_d = GNT1;
                    else if (bus.din0_valid) state_d = GNT0;
                    else                     state_d = IDLE;
                end
            end
            GNT1: begin
                if (fin1) begin
                    last_gnt_d = 1'b1;
                    if (bus.din0_valid)      state_d = GNT0;
                    else if (bus.din1_valid) state_d = GNT1;
                    else                     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0)      sel_d = 1'b1;
        else if (state_d == GNT1) sel_d = 1'b0;
    end

    // Grant state; last_gnt resets to port 1 so port 0 wins first
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            sel_q      <= sel_d;
        end
    end

    // Output register: load on accept, drain when consumed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q <= '0;
            dl_q   <= 1'b0;
            dv_q   <= 1'b0;
        end else if (acc0 || acc1) begin
            dout_q <= mux_d;
            dl_q   <= mux_last;
            dv_q   <= 1'b1;
        end else if (bus.dout_ready) begin
            dv_q   <= 1'b0;
        end
    end

    // Per-port packet counters, bumped on last-beat accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (fin0) cnt0_q <= cnt0_q + 1'b1;
            if (fin1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign bus.din0_ready = gnt0 && out_free;
    assign bus.din1_ready = gnt1 && out_free;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.dout_last  = dl_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.pkt_cnt0   = cnt0_q;
    assign bus.pkt_cnt1   = cnt1_q;
endmodule

// File: doc/baseerat_mux_sched.md
# baseerat_mux_sched

Two-requester, packet-granular round-robin scheduler for the 2:1 section mux datapath. It owns the `sel` decision and drives a registered output stage. It arbitrates between two valid/ready streams, holds a grant for a full packet (until `last`), and alternates fairly when both requesters contend. It sits in front of any consumer that previously took a statically muxed pair of buses, and adds backpressure and per-port packet counters.

## Interface
- `DATA_WIDTH`, 32: beat width. Must be a multiple of 16; the datapath is built from 16-bit sections.
- `CNT_WIDTH`, 16: width of each per-port packet counter.
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk` at system level.
- `din0` in DATA_WIDTH: port 0 beat data.
- `din0_valid` in 1: port 0 beat valid.
- `din0_last` in 1: port 0 final beat of packet.
- `din0_ready` out 1: port 0 beat accepted when high together with `din0_valid`.
- `din1`, `din1_valid`, `din1_last`, `din1_ready`: same as port 0, for port 1.
- `dout` out DATA_WIDTH: registered output beat.
- `dout_valid` out 1: output beat valid.
- `dout_last` out 1: output beat is final beat of packet.
- `dout_ready` in 1: downstream accepts output when high together with `dout_valid`.
- `sel` out 1: current grant. 1 = port 0 (din0), 0 = port 1 (din1). This matches the team mux polarity.
- `busy` out 1: a grant is held (state is not IDLE).
- `pkt_cnt0` out CNT_WIDTH: packets forwarded from port 0; wraps modulo 2^CNT_WIDTH.
- `pkt_cnt1` out CNT_WIDTH: packets forwarded from port 1; wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE, GNT0, GNT1. `last_gnt` records the most recently served port; it resets to port 1 so port 0 wins the first contention.
- IDLE transitions:
  - Only port 0 valid → GNT0.
  - Only port 1 valid → GNT1.
  - Both valid → grant the port that is not `last_gnt`.
  - Neither valid → stay in IDLE.
- GNTx: the grant is held across beats until a beat with `dinx_last` is accepted. No preemption mid-packet.
- On acceptance of a last beat from port x, the next state is decided in the same cycle, with no bubble:
  - Other port valid → GNT of the other port.
  - Else port x valid → GNTx again.
  - Else → IDLE.
  - `last_gnt` ← x.
- `sel` = 1 in GNT0, 0 in GNT1. In IDLE, `sel` holds its previous value.
- Only the granted port's ready can be high: `dinx_ready = (state==GNTx) && (!dout_valid || dout_ready)`. The non-granted ready is 0.
- Output register (one entry):
  - Loads `{dout, dout_last}` from the granted port on every accepted input beat, and `dout_valid` goes to 1.
  - When a beat is consumed with no new load, `dout_valid` goes to 0.
  - Holds while `dout_valid && !dout_ready`.
- `pkt_cnt0` and `pkt_cnt1` increment on acceptance of a last beat at the input side, and wrap to 0 after all-ones.
- `din*_valid` may drop mid-packet; the grant is kept and ready simply yields no transfer.
- A single-beat packet (valid and last in the first beat) is legal.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `dout_last` = 0, `din0_ready` = 0, `din1_ready` = 0, `sel` = 0, `busy` = 0, `pkt_cnt0` = 0, `pkt_cnt1` = 0, state = IDLE, `last_gnt` = port 1.
- Grant latency: valid seen in IDLE at cycle N → state GNTx and `dinx_ready` high at N+1 (if the output is free) → first accept at N+1.
- Data latency: beat accepted at cycle N appears on `dout` with `dout_valid` at N+1.
- Throughput: 1 beat per cycle while `dout_ready` = 1, including across packet boundaries and grant switches.
- Backpressure: while `dout_ready` = 0 and `dout_valid` = 1, all input readies are 0. No data is lost or reordered.
- Simultaneous load and unload of the output register in one cycle is permitted and required for full rate.
- Reset mid-packet: the packet is abandoned, the output is invalidated immediately, and no counter increments for it.

## Test plan
- Reset: assert `resetn`=0 mid-packet with `dout_valid`=1 → all outputs read their reset values asynchronously, before the next edge. After release with both ports valid, port 0 is granted first (`sel`=1).
- Single port streaming: port 1 sends 3 packets of 4 beats each (data 0x0001..0x000C) with `dout_ready`=1 → `dout` is 0x0001..0x000C on consecutive cycles, `dout_last` is high on beats 4, 8 and 12, `sel`=0 throughout, `pkt_cnt1`=3, `pkt_cnt0`=0.
- Contention: both ports continuously valid with 2-beat packets → output packet sources alternate 0,1,0,1,… with no idle cycle between packets; after 8 packets `pkt_cnt0`=4 and `pkt_cnt1`=4.
- Packet lock: port 0 packet of 5 beats in progress, port 1 raises valid at beat 2 → `din1_ready` stays 0 until port 0's last beat is accepted, and port 1's first beat is accepted on the next cycle.
- Backpressure: `dout_ready` held 0 for 3 cycles mid-packet → `dout` and `dout_valid` stay stable, `din*_ready`=0, and after release the beats emerge in order with none duplicated.
- Wrap: with `CNT_WIDTH`=4, forward 17 single-beat packets on port 0 → `pkt_cnt0` reads 0xF after 15 packets, 0x0 after 16, 0x1 after 17.
